// File: rtl/i2c_slave_read_byte.sv
// I2C slave byte receiver: samples 8 bits MSB first on synced SCL rising edges and flags START/STOP seen mid-byte.
// Optional per-line glitch filter built when I2C_SLAVE_READ_GLITCH_FILTER_EN is defined.
module i2c_slave_read_byte #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       scl,
    input  logic       sda,
    output logic [7:0] data,
    output logic       finish,
    output logic       busy,
    output logic       start_detected,
    output logic       stop_detected
);
    // state     | meaning
    // IDLE      | waiting for enable from the slave FSM
    // WAIT_HIGH | SCL low, waiting for the next rising edge to sample SDA
    // HIGH      | SCL high, SDA must stay stable until SCL falls
    // DONE      | all 8 bits in, publish byte and pulse finish
    // ABORT     | SDA moved while SCL high, report START or STOP
    typedef enum logic [2:0] {IDLE, WAIT_HIGH, HIGH, DONE, ABORT} state_t;

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILTER_CYCLES < 1) begin : g_param_check
        $error("i2c_slave_read_byte: illegal SYNC_STAGES or FILTER_CYCLES");
    end

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [1:0]             line_sync, line_q;
    logic                   scl_q, sda_q, scl_d, sda_d;
    logic                   scl_rise, scl_fall, sda_chg;
    logic [7:0]             shreg;
    logic [3:0]             bit_cnt;
    logic                   ev_start;
    logic                   accept, sample, abort_go;

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
        end
    end

    assign line_sync = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

`ifdef I2C_SLAVE_READ_GLITCH_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);
    logic [1:0]    line_filt;
    logic [CW-1:0] flt_cnt [2];

    // Terminal count reached only after FILTER_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            line_filt <= 2'b11;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= CW'(FILTER_CYCLES - 1);
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (line_sync[i] == line_filt[i]) begin
                    flt_cnt[i] <= CW'(FILTER_CYCLES - 1);
                end else if (flt_cnt[i] == '0) begin
                    line_filt[i] <= line_sync[i];
                    flt_cnt[i]   <= CW'(FILTER_CYCLES - 1);
                end else begin
                    flt_cnt[i] <= flt_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign line_q = line_filt;
`else
    assign line_q = line_sync;
`endif

    assign scl_q = line_q[0];
    assign sda_q = line_q[1];

    always_ff @(posedge clock) begin
        if (reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_q;
            sda_d <= sda_q;
        end
    end

    assign scl_rise = scl_q & ~scl_d;
    assign scl_fall = ~scl_q & scl_d;
    assign sda_chg  = sda_q ^ sda_d;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sample     = 1'b0;
        abort_go   = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    accept     = 1'b1;
                    state_next = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (scl_rise) begin
                    sample     = 1'b1;
                    state_next = HIGH;
                end
            end
            HIGH: begin
                // SCL fall takes priority: SDA moving with SCL is a hold issue, not an event.
                if (scl_fall) begin
                    state_next = (bit_cnt == 4'd8) ? DONE : WAIT_HIGH;
                end else if (sda_chg) begin
                    abort_go   = 1'b1;
                    state_next = ABORT;
                end
            end
            DONE:    state_next = IDLE;
            ABORT:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg          <= 8'h00;
            bit_cnt        <= 4'd0;
            ev_start       <= 1'b0;
            data           <= 8'h00;
            finish         <= 1'b0;
            busy           <= 1'b0;
            start_detected <= 1'b0;
            stop_detected  <= 1'b0;
        end else begin
            finish         <= (state == DONE);
            start_detected <= (state == ABORT) &&  ev_start;
            stop_detected  <= (state == ABORT) && !ev_start;
            if (accept) begin
                bit_cnt <= 4'd0;
                busy    <= 1'b1;
            end else if (state == DONE || state == ABORT) begin
                busy <= 1'b0;
            end
            if (sample) begin
                shreg   <= {shreg[6:0], sda_q};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (abort_go) ev_start <= ~sda_q;
            if (state == DONE) data <= shreg;
        end
    end

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Directed bench for i2c_slave_read_byte: bit-banged master, SCL = clk/8, hand-computed expectations.
module tb_i2c_slave_read_byte;
    logic       clk = 1'b0;
    logic       reset, enable, scl, sda;
    logic [7:0] data;
    logic       finish, busy, start_detected, stop_detected;

    int checks   = 0;
    int failures = 0;
    int start_cnt = 0;
    int stop_cnt  = 0;
    logic [7:0] fin_q [$];
    logic [7:0] t2_bytes [4] = '{8'h13, 8'hDF, 8'h00, 8'hFF};

    i2c_slave_read_byte #(.SYNC_STAGES(2), .FILTER_CYCLES(3)) dut (
        .clock          (clk),
        .reset          (reset),
        .enable         (enable),
        .scl            (scl),
        .sda            (sda),
        .data           (data),
        .finish         (finish),
        .busy           (busy),
        .start_detected (start_detected),
        .stop_detected  (stop_detected)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (finish)         fin_q.push_back(data);
        if (start_detected) start_cnt++;
        if (stop_detected)  stop_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
    endtask

    // Sends nbits MSB first; gl_bit selects a bit whose SCL-high phase gets an SDA toggle,
    // restored after two cycles when gl_restore is set.
    task automatic send_bits(input logic [7:0] b, input int nbits, input int gl_bit,
                             input bit gl_restore, input bit busy_chk);
        for (int i = 1; i <= nbits; i++) begin
            sda = b[8-i];
            repeat (3) @(negedge clk);
            scl = 1'b1;
            if (i == gl_bit) begin
                @(negedge clk);
                sda = ~sda;
                repeat (2) @(negedge clk);
                if (gl_restore) sda = ~sda;
                @(negedge clk);
            end else begin
                repeat (2) @(negedge clk);
                if (busy_chk) chk("busy_hi", busy, 1);
                repeat (2) @(negedge clk);
            end
            scl = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_finish(input logic [7:0] exp, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (finish) seen = 1'b1;
        end
        chk({tag, "_fin"}, seen, 1);
        if (seen) begin
            chk({tag, "_data"}, data, exp);
            chk({tag, "_busy_lo"}, busy, 0);
        end
    endtask

    initial begin
        int n_fin;
        reset = 1'b1; enable = 1'b0; scl = 1'b1; sda = 1'b1;
        settle(3);
        chk("rst_data", data, 8'h00);
        chk("rst_finish", finish, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_detected, 0);
        chk("rst_stop", stop_detected, 0);
        reset = 1'b0;

        // Bus START while idle must not be reported
        repeat (2) @(negedge clk);
        sda = 1'b0;
        repeat (4) @(negedge clk);
        scl = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single byte A5
        pulse_enable();
        send_bits(8'hA5, 8, 0, 1'b0, 1'b1);
        wait_finish(8'hA5, "t1");
        settle(3);
        chk("t1_nfin", fin_q.size(), 1);
        chk("t1_start", start_cnt, 0);
        chk("t1_stop", stop_cnt, 0);

        // 2: back-to-back bytes
        fin_q.delete();
        for (int k = 0; k < 4; k++) begin
            pulse_enable();
            send_bits(t2_bytes[k], 8, 0, 1'b0, 1'b0);
            wait_finish(t2_bytes[k], "t2");
        end
        settle(3);
        chk("t2_nfin", fin_q.size(), 4);
        for (int k = 0; k < 4 && k < fin_q.size(); k++) chk("t2_order", fin_q[k], t2_bytes[k]);

        // 3: SDA 0->1 during SCL high of bit 3 (C0: bit3 = 0) -> STOP
        n_fin = fin_q.size();
        pulse_enable();
        send_bits(8'hC0, 3, 3, 1'b0, 1'b0);
        settle(4);
        chk("t3_stop", stop_cnt, 1);
        chk("t3_start", start_cnt, 0);
        chk("t3_busy", busy, 0);
        chk("t3_data", data, 8'hFF);
        chk("t3_nfin", fin_q.size(), n_fin);

        // 4: SDA 1->0 during SCL high of bit 5 (F8: bit5 = 1) -> START, then 5A
        pulse_enable();
        send_bits(8'hF8, 5, 5, 1'b0, 1'b0);
        settle(4);
        chk("t4_start", start_cnt, 1);
        chk("t4_stop", stop_cnt, 1);
        chk("t4_busy", busy, 0);
        chk("t4_nfin", fin_q.size(), n_fin);
        pulse_enable();
        send_bits(8'h5A, 8, 0, 1'b0, 1'b0);
        wait_finish(8'h5A, "t4");

        // 5: reset pulse after bit 4, then 3C
        settle(3);
        n_fin = fin_q.size();
        pulse_enable();
        send_bits(8'h3C, 4, 0, 1'b0, 1'b0);
        chk("t5_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_data", data, 8'h00);
        chk("t5_finish", finish, 0);
        chk("t5_busy", busy, 0);
        chk("t5_start", start_detected, 0);
        chk("t5_stop", stop_detected, 0);
        reset = 1'b0;
        settle(6);
        chk("t5_nfin", fin_q.size(), n_fin);
        chk("t5_events", start_cnt + stop_cnt, 2);
        pulse_enable();
        send_bits(8'h3C, 8, 0, 1'b0, 1'b0);
        wait_finish(8'h3C, "t5");

        // 6: 2-cycle SDA low glitch during SCL high of bit 2 in C3
        settle(3);
        n_fin = fin_q.size();
        pulse_enable();
        send_bits(8'hC3, 8, 2, 1'b1, 1'b0);
`ifdef I2C_SLAVE_READ_GLITCH_FILTER_EN
        wait_finish(8'hC3, "t6");
        settle(3);
        chk("t6_nfin", fin_q.size(), n_fin + 1);
        chk("t6_start", start_cnt, 1);
`else
        settle(6);
        chk("t6_nfin", fin_q.size(), n_fin);
        chk("t6_start", start_cnt, 2);
        chk("t6_data", data, 8'h3C);
`endif
        chk("t6_stop", stop_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
